// File: rtl/uart_rx_fifo.sv
// UART 8N1 receiver feeding a first-word fall-through FIFO.
// The head byte and its valid flag drive the cpu's data_in/data_available directly.
module uart_rx_fifo #(
   parameter int unsigned CLKS_PER_BIT    = 868,
   parameter int unsigned DATA_WIDTH      = 8,
   parameter int unsigned FIFO_ADDR_WIDTH = 4
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       rx,
   output logic [DATA_WIDTH-1:0]      data,
   output logic                       data_available,
   input  logic                       pop,
   output logic [FIFO_ADDR_WIDTH:0]   count,
   output logic                       framing_error,
   output logic                       overflow
);

   localparam int unsigned CntW    = $clog2(CLKS_PER_BIT);
   localparam int unsigned IdxW    = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
   localparam int unsigned Depth   = 1 << FIFO_ADDR_WIDTH;
   localparam int unsigned CountW  = FIFO_ADDR_WIDTH + 1;

   localparam logic [CntW-1:0]   HalfLoad = CntW'(CLKS_PER_BIT / 2 - 1);
   localparam logic [CntW-1:0]   FullLoad = CntW'(CLKS_PER_BIT - 1);
   localparam logic [IdxW-1:0]   LastIdx  = IdxW'(DATA_WIDTH - 1);
   localparam logic [CountW-1:0] Full     = CountW'(Depth);

   typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

   state_e                      state_q, state_d;
   logic [CntW-1:0]             cnt_q, cnt_d;
   logic [IdxW-1:0]             idx_q, idx_d;
   logic [DATA_WIDTH-1:0]       shreg_q, shreg_d;
   logic                        rx_meta_q, rx_meta_d;
   logic                        rx_s_q, rx_s_d;
   logic                        rx_dly_q, rx_dly_d;
   logic                        fe_q, fe_d;
   logic                        ovf_q, ovf_d;
   logic [FIFO_ADDR_WIDTH-1:0]  wr_ptr_q, wr_ptr_d;
   logic [FIFO_ADDR_WIDTH-1:0]  rd_ptr_q, rd_ptr_d;
   logic [CountW-1:0]           count_q, count_d;
   logic [DATA_WIDTH-1:0]       mem_q [Depth];

   logic rx_fall;
   logic push_req;
   logic do_push;
   logic do_pop;

   // Receiver: sample points fall mid-bit, counted from the synchronized falling edge.
   always_comb begin
      rx_meta_d = rx;
      rx_s_d    = rx_meta_q;
      rx_dly_d  = rx_s_q;
      rx_fall   = rx_dly_q & ~rx_s_q;
      state_d   = state_q;
      cnt_d     = cnt_q;
      idx_d     = idx_q;
      shreg_d   = shreg_q;
      push_req  = 1'b0;
      fe_d      = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (rx_fall) begin
               cnt_d   = HalfLoad;
               state_d = StStart;
            end
         end
         StStart: begin
            if (cnt_q != '0) begin
               cnt_d = cnt_q - 1'b1;
            end else if (rx_s_q) begin
               state_d = StIdle;
            end else begin
               cnt_d   = FullLoad;
               idx_d   = '0;
               state_d = StData;
            end
         end
         StData: begin
            if (cnt_q != '0) begin
               cnt_d = cnt_q - 1'b1;
            end else begin
               shreg_d[idx_q] = rx_s_q;
               cnt_d          = FullLoad;
               if (idx_q == LastIdx) begin
                  state_d = StStop;
               end else begin
                  idx_d = idx_q + 1'b1;
               end
            end
         end
         StStop: begin
            if (cnt_q != '0) begin
               cnt_d = cnt_q - 1'b1;
            end else begin
               state_d = StIdle;
               if (rx_s_q) begin
                  push_req = 1'b1;
               end else begin
                  fe_d = 1'b1;
               end
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // A pop on a full FIFO frees the slot the simultaneous push needs.
   always_comb begin
      do_pop   = pop & (count_q != '0);
      do_push  = push_req & ((count_q != Full) | do_pop);
      ovf_d    = ovf_q | (push_req & ~do_push);
      wr_ptr_d = wr_ptr_q + FIFO_ADDR_WIDTH'(do_push);
      rd_ptr_d = rd_ptr_q + FIFO_ADDR_WIDTH'(do_pop);
      count_d  = count_q;
      if (do_push && !do_pop) begin
         count_d = count_q + 1'b1;
      end else if (do_pop && !do_push) begin
         count_d = count_q - 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= StIdle;
         cnt_q     <= '0;
         idx_q     <= '0;
         shreg_q   <= '0;
         rx_meta_q <= 1'b1;
         rx_s_q    <= 1'b1;
         rx_dly_q  <= 1'b1;
         fe_q      <= 1'b0;
         ovf_q     <= 1'b0;
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         count_q   <= '0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         idx_q     <= idx_d;
         shreg_q   <= shreg_d;
         rx_meta_q <= rx_meta_d;
         rx_s_q    <= rx_s_d;
         rx_dly_q  <= rx_dly_d;
         fe_q      <= fe_d;
         ovf_q     <= ovf_d;
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
         count_q   <= count_d;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) begin
         mem_q[wr_ptr_q] <= shreg_q;
      end
   end

   assign data_available = (count_q != '0);
   assign data           = data_available ? mem_q[rd_ptr_q] : '0;
   assign count          = count_q;
   assign framing_error  = fe_q;
   assign overflow       = ovf_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Bench for uart_rx_fifo: frame-level reference model (queue of bytes plus the cycle
// each frame's stop bit is sampled) compared against the DUT on every falling clock edge.
module tb_uart_rx_fifo;

   localparam int unsigned Clks  = 4;
   localparam int unsigned Aw    = 2;
   localparam int unsigned Depth = 1 << Aw;
   // Edges from the start bit's first edge to the stop-bit sample: 2 sync stages,
   // edge detect, half a bit, then 9 full bits.
   localparam int unsigned PushLag = 2 + Clks / 2 + 9 * Clks;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         rx = 1'b1;
   logic         pop = 1'b0;
   logic [7:0]   data;
   logic         data_available;
   logic [Aw:0]  count;
   logic         framing_error;
   logic         overflow;

   uart_rx_fifo #(
      .CLKS_PER_BIT   (Clks),
      .DATA_WIDTH     (8),
      .FIFO_ADDR_WIDTH(Aw)
   ) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .rx            (rx),
      .data          (data),
      .data_available(data_available),
      .pop           (pop),
      .count         (count),
      .framing_error (framing_error),
      .overflow      (overflow)
   );

   initial forever #5 clk = ~clk;

   int unsigned edge_n = 0;
   always @(posedge clk) edge_n <= edge_n + 1;

   typedef struct {
      int unsigned at_edge;
      logic [7:0]  b;
      bit          fe;
   } ev_t;

   ev_t        evq[$];
   logic [7:0] mq[$];
   bit         ovf_m = 1'b0;
   bit         fe_m = 1'b0;
   bit         rand_pop = 1'b0;
   int         n_vec = 0;
   int         n_err = 0;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s at edge %0d: got %0h, expected %0h", name, edge_n, got, exp);
      end
   endtask

   // Advance the model across the coming rising edge.
   task automatic apply(input int unsigned upc);
      bit         popping;
      bit         pushing;
      logic [7:0] b;
      ev_t        ev;
      popping = pop && (mq.size() > 0);
      pushing = 1'b0;
      b       = 8'h00;
      if (evq.size() > 0 && evq[0].at_edge == upc) begin
         ev = evq.pop_front();
         b  = ev.b;
         if (ev.fe) fe_m = 1'b1;
         else if (mq.size() < Depth || popping) pushing = 1'b1;
         else ovf_m = 1'b1;
      end
      if (popping) void'(mq.pop_front());
      if (pushing) mq.push_back(b);
   endtask

   logic [7:0] exp_data;
   initial begin
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            mq.delete();
            evq.delete();
            ovf_m = 1'b0;
            fe_m  = 1'b0;
         end
         exp_data = (mq.size() != 0) ? mq[0] : 8'h00;
         check("m_data_available", data_available, (mq.size() != 0));
         check("m_data", data, exp_data);
         check("m_count", count, mq.size());
         check("m_overflow", overflow, ovf_m);
         check("m_framing_error", framing_error, fe_m);
         fe_m = 1'b0;
         if (rst_n) apply(edge_n + 1);
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
      if (rand_pop) pop = ($urandom_range(0, 3) == 0);
   endtask

   // Called just after a rising edge; returns just after the last stop-bit edge.
   task automatic send_frame(input logic [7:0] b, input bit stop_lo);
      evq.push_back('{edge_n + 1 + PushLag, b, stop_lo});
      rx = 1'b0;
      repeat (Clks) tick();
      for (int i = 0; i < 8; i++) begin
         rx = b[i];
         repeat (Clks) tick();
      end
      rx = ~stop_lo;
      repeat (Clks) tick();
      rx = 1'b1;
   endtask

   task automatic do_pop_expect(input string name, input logic [7:0] exp);
      check(name, data, exp);
      pop = 1'b1;
      tick();
      pop = 1'b0;
   endtask

   task automatic reset_pulse();
      rst_n = 1'b0;
      repeat (2) tick();
      rst_n = 1'b1;
      tick();
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: run did not finish, got timeout, expected completion");
      $fatal(1, "watchdog expired");
   end

   int r;
   initial begin
      repeat (3) tick();
      check("rst_data", data, 8'h00);
      check("rst_avail", data_available, 1'b0);
      check("rst_count", count, 0);
      check("rst_overflow", overflow, 1'b0);
      rst_n = 1'b1;
      repeat (4) tick();

      send_frame(8'hA5, 1'b0);
      check("a5_not_yet", data_available, 1'b0);
      tick();
      check("a5_avail", data_available, 1'b1);
      check("a5_data", data, 8'hA5);
      check("a5_count", count, 1);
      pop = 1'b1;
      tick();
      pop = 1'b0;
      check("a5_pop_avail", data_available, 1'b0);
      check("a5_pop_count", count, 0);
      check("a5_pop_data", data, 8'h00);
      repeat (3) tick();

      rx = 1'b0;
      tick();
      rx = 1'b1;
      repeat (8) tick();
      check("glitch_count", count, 0);
      check("glitch_fe", framing_error, 1'b0);

      send_frame(8'h3C, 1'b1);
      check("fe_before", framing_error, 1'b0);
      tick();
      check("fe_pulse", framing_error, 1'b1);
      tick();
      check("fe_after", framing_error, 1'b0);
      check("fe_count", count, 0);
      repeat (2) tick();

      for (int i = 1; i <= 5; i++) begin
         send_frame(8'(i), 1'b0);
         repeat (2) tick();
      end
      check("ovf_count", count, 4);
      check("ovf_flag", overflow, 1'b1);
      for (int i = 1; i <= 4; i++) do_pop_expect("ovf_pop_data", 8'(i));
      check("ovf_drained", data_available, 1'b0);
      check("ovf_sticky", overflow, 1'b1);
      reset_pulse();
      check("ovf_reset", overflow, 1'b0);

      for (int i = 1; i <= 4; i++) begin
         send_frame(8'(i), 1'b0);
         repeat (2) tick();
      end
      check("full_count", count, 4);
      send_frame(8'h05, 1'b0);
      pop = 1'b1;
      tick();
      pop = 1'b0;
      check("pp_count", count, 4);
      check("pp_overflow", overflow, 1'b0);
      for (int i = 2; i <= 5; i++) do_pop_expect("pp_pop_data", 8'(i));
      check("pp_drained", data_available, 1'b0);

      rx = 1'b0;
      repeat (Clks) tick();
      for (int i = 0; i < 3; i++) begin
         rx = (i == 1);
         repeat (Clks) tick();
      end
      rst_n = 1'b0;
      rx    = 1'b1;
      tick();
      check("midrst_count", count, 0);
      check("midrst_avail", data_available, 1'b0);
      check("midrst_data", data, 8'h00);
      tick();
      rst_n = 1'b1;
      repeat (3) tick();
      send_frame(8'h7E, 1'b0);
      tick();
      check("after_rst_data", data, 8'h7E);
      check("after_rst_count", count, 1);
      pop = 1'b1;
      tick();
      pop = 1'b0;
      tick();

      rand_pop = 1'b1;
      repeat (40) begin
         r = $urandom_range(0, 9);
         if (r == 0) begin
            rx = 1'b0;
            tick();
            rx = 1'b1;
            repeat (8) tick();
         end else begin
            send_frame(8'($urandom), (r == 1));
         end
         repeat ($urandom_range(2, 6)) tick();
      end
      rand_pop = 1'b0;
      pop = 1'b1;
      repeat (Depth + 1) tick();
      pop = 1'b0;
      tick();
      check("drain_count", count, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
- Serial input front-end for the Brainfuck processor: receives UART 8N1 frames on `rx` and buffers the received bytes in a FIFO.
- Presents the head byte on `data`/`data_available`, which wire directly to the cpu's `data_in`/`data_available`.
- The cpu's `data_read` strobe drives `pop`; the FIFO discards the head byte on that clock edge.

Parameters:
- CLKS_PER_BIT, 868, clk cycles per UART bit period; must be >= 4.
- DATA_WIDTH, 8, received word width and number of data bits per frame.
- FIFO_ADDR_WIDTH, 4, log2 of FIFO depth (default depth 16).

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- rx  input  1  asynchronous serial line; idles high.
- data  output  DATA_WIDTH  head-of-FIFO byte (first-word fall-through); 0 when empty.
- data_available  output  1  high when FIFO non-empty.
- pop  input  1  consume head byte on this edge; connect to cpu data_read.
- count  output  FIFO_ADDR_WIDTH+1  bytes currently buffered.
- framing_error  output  1  one-cycle pulse when a frame's stop bit samples low.
- overflow  output  1  sticky; set when a valid byte is dropped because FIFO full.

Behaviour:
- Reset: rst_n low clears all of the following immediately, regardless of clock:
  - FIFO pointers and count = 0; data = 0; data_available = 0.
  - framing_error = 0; overflow = 0; FSM = IDLE.
  - Synchronizer flops = 1.
  - A frame in progress is abandoned. The receiver resumes only after rx is seen high, then a new falling edge.
- Synchronizer: rx passes through 2 flops (rx_s). Edge detect uses rx_s and a third delayed copy.
- FSM states:
  - IDLE: on a rx_s falling edge, load the bit counter with CLKS_PER_BIT/2 - 1 (integer division) and go to START.
  - START: count down to 0, then sample rx_s.
    - If high: false start, return to IDLE.
    - If low: load CLKS_PER_BIT-1, bit index = 0, go to DATA.
  - DATA: on each counter expiry, shift rx_s into bit[bit index], LSB first, and reload the counter.
    - After bit DATA_WIDTH-1 is taken, go to STOP.
  - STOP: on counter expiry, sample rx_s.
    - High: push the byte. Low: pulse framing_error for exactly 1 cycle and discard the byte.
    - Either way, return to IDLE the same cycle.
    - The next falling edge is accepted from the following cycle.
- Latency: the byte is visible on data/data_available on the cycle after the stop-bit sample edge.
- FIFO:
  - Circular buffer of 2^FIFO_ADDR_WIDTH entries; pointers wrap modulo depth.
  - data is combinational from the read pointer when non-empty, else 0.
- pop rules:
  - pop with data_available=0 is ignored; no pointer or count change, no error.
  - pop is level-sampled each edge: pop held high for N cycles removes up to N bytes.
- push rules:
  - Push when count < depth: write the byte, count+1.
  - Push when count == depth and no pop that edge: drop the byte, set overflow; FIFO contents unchanged.
- Push and pop on the same edge:
  - When count == depth, the pop frees a slot, so the push is accepted: count unchanged, no overflow.
  - When count == 0, the push is accepted and the pop is ignored: count becomes 1.
  - Otherwise count is unchanged and both pointers advance.
- count is exact at all times: 0..depth inclusive.
- overflow clears only on reset.

Test Plan:
- CLKS_PER_BIT=4, FIFO_ADDR_WIDTH=2. Send frame 0xA5, then hold rx high:
  - data_available rises 1 cycle after the stop sample; data=0xA5, count=1.
  - pop for 1 cycle -> data_available=0, count=0, data=0.
- rx low pulse of 1 clk (glitch), then high -> FSM returns to IDLE from START; no push, no framing_error.
- Send 0x3C with the stop bit driven low -> framing_error high exactly 1 cycle; count stays 0.
- Send 5 bytes 0x01..0x05 with no pops -> count=4, overflow=1. Pops return 0x01,0x02,0x03,0x04, then data_available=0.
- Fill to 4 bytes, then assert pop on the exact edge the 5th byte pushes -> count stays 4, overflow stays 0. Pops return bytes 2..5.
- Drive rst_n low mid-DATA of a frame, release with rx high -> all outputs 0, count=0. The next full frame 0x7E is received correctly.
